// File: rtl/bus_grant_fsm.sv
// -----------------------------------------------------------------------------
// bus_grant_fsm
// Bus-ownership controller. Arbitrates NREQ requesters onto a single shared bus
// using a one-hot FSM (IDLE, BWAIT, BBUSY, BFREE). The winner is chosen either by
// fixed priority (lowest index) or by round-robin. The controller also provides
// an acknowledge timeout, requester abort, a programmable free/turnaround
// period, and recovery from illegal (non-one-hot) states. All outputs are
// registered.
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   req          in   [NREQ-1:0] per-requester request level
//   done         in   [NREQ-1:0] release pulse (only the owner's bit counts)
//   bus_ack      in   target accepted the granted owner
//   gnt          out  [NREQ-1:0] one-hot grant, zero when there is no owner
//   state        out  [3:0] one-hot state: b0 IDLE, b1 BBUSY, b2 BWAIT, b3 BFREE
//   owner_id     out  [OW-1:0] index of the current/last owner
//   timeout_err  out  one-cycle pulse on acknowledge timeout
//   busy         out  high in BWAIT or BBUSY
// -----------------------------------------------------------------------------
module bus_grant_fsm #(
  parameter int NREQ        = 4,
  parameter int RR_MODE     = 0,
  parameter int TW          = 8,
  parameter int TIMEOUT     = 200,
  parameter int FREE_CYCLES = 1,
  localparam int OW         = (NREQ > 2) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] done,
  input  logic            bus_ack,
  output logic [NREQ-1:0] gnt,
  output logic [3:0]      state,
  output logic [OW-1:0]   owner_id,
  output logic            timeout_err,
  output logic            busy
);

  typedef enum logic [3:0] {
    S_IDLE  = 4'b0001,
    S_BBUSY = 4'b0010,
    S_BWAIT = 4'b0100,
    S_BFREE = 4'b1000
  } state_e;

  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [3:0]    FREE_LAST = 4'(FREE_CYCLES - 1);

  // The state register is plain logic so an illegal (non-one-hot) value can be
  // held and detected; the enum supplies the legal encodings.
  logic [3:0]      state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic            terr_q, terr_d;
  logic            busy_q, busy_d;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic [3:0]      fcnt_q, fcnt_d;
  logic [OW-1:0]   rr_q, rr_d;

  logic [OW-1:0]   start_s;
  logic [OW-1:0]   win_s;
  logic            found_s;
  logic [OW-1:0]   win_next_s;
  int              idx_s;

  // Decode an owner index into a one-hot grant vector.
  function automatic logic [NREQ-1:0] onehot(input logic [OW-1:0] idx);
    logic [NREQ-1:0] oh;
    oh = '0;
    for (int i = 0; i < NREQ; i++) begin
      oh[i] = (OW'(i) == idx);
    end
    return oh;
  endfunction

  // Winner search start: the round-robin pointer, or index 0 for fixed priority.
  always_comb begin
    if (RR_MODE != 0) begin
      start_s = rr_q;
    end else begin
      start_s = '0;
    end
  end

  // First requester at or after start_s, wrapping modulo NREQ.
  always_comb begin
    found_s = 1'b0;
    win_s   = '0;
    idx_s   = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx_s = (int'(start_s) + i) % NREQ;
      if (!found_s && req[idx_s]) begin
        found_s = 1'b1;
        win_s   = OW'(idx_s);
      end
    end
  end

  // Pointer after a grant: one past the winner, NREQ-1 wrapping to 0.
  always_comb begin
    if (win_s == OW'(NREQ - 1)) begin
      win_next_s = '0;
    end else begin
      win_next_s = win_s + OW'(1);
    end
  end

  // Next-state and next-output logic; hold everything by default.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    terr_d  = 1'b0;
    busy_d  = busy_q;
    tcnt_d  = tcnt_q;
    fcnt_d  = fcnt_q;
    rr_d    = rr_q;
    case (state_q)
      S_IDLE: begin
        if (found_s) begin
          state_d = S_BWAIT;
          owner_d = win_s;
          gnt_d   = onehot(win_s);
          tcnt_d  = '0;
          busy_d  = 1'b1;
          rr_d    = win_next_s;
        end else begin
          gnt_d  = '0;
          busy_d = 1'b0;
        end
      end
      S_BWAIT: begin
        // Coincident events resolve as ack > abort > timeout.
        if (bus_ack) begin
          state_d = S_BBUSY;
        end else if (!req[owner_q]) begin
          state_d = S_BFREE;
          gnt_d   = '0;
          busy_d  = 1'b0;
          fcnt_d  = '0;
        end else if (tcnt_q == TMO_LAST) begin
          state_d = S_BFREE;
          gnt_d   = '0;
          busy_d  = 1'b0;
          fcnt_d  = '0;
          terr_d  = 1'b1;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      S_BBUSY: begin
        if (done[owner_q] || !req[owner_q]) begin
          state_d = S_BFREE;
          gnt_d   = '0;
          busy_d  = 1'b0;
          fcnt_d  = '0;
        end else begin
          state_d = S_BBUSY;
        end
      end
      S_BFREE: begin
        gnt_d  = '0;
        busy_d = 1'b0;
        if (fcnt_q == FREE_LAST) begin
          state_d = S_IDLE;
          fcnt_d  = '0;
        end else begin
          fcnt_d = fcnt_q + 4'd1;
        end
      end
      default: begin
        // Non-one-hot state: drop the grant and return to IDLE quietly.
        state_d = S_IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
        tcnt_d  = '0;
        fcnt_d  = '0;
      end
    endcase
  end

  // State, output and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      terr_q  <= 1'b0;
      busy_q  <= 1'b0;
      tcnt_q  <= '0;
      fcnt_q  <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      terr_q  <= terr_d;
      busy_q  <= busy_d;
      tcnt_q  <= tcnt_d;
      fcnt_q  <= fcnt_d;
      rr_q    <= rr_d;
    end
  end

  assign state       = state_q;
  assign gnt         = gnt_q;
  assign owner_id    = owner_q;
  assign timeout_err = terr_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_bus_grant_fsm.sv
// Scoreboard bench for bus_grant_fsm: one fixed-priority instance (TIMEOUT=5)
// and one round-robin instance. Stimulus pushes the expected post-edge outputs;
// a monitor pops one entry per clock edge and compares.
module tb_bus_grant_fsm;

  localparam logic [3:0] ST_I = 4'b0001;
  localparam logic [3:0] ST_B = 4'b0010;
  localparam logic [3:0] ST_W = 4'b0100;
  localparam logic [3:0] ST_F = 4'b1000;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;

  logic [3:0] req_f  = 4'b0000, done_f = 4'b0000;
  logic       ack_f  = 1'b0;
  logic [3:0] gnt_f, state_f;
  logic [1:0] owner_f;
  logic       terr_f, busy_f;

  logic [3:0] req_r  = 4'b0000, done_r = 4'b0000;
  logic       ack_r  = 1'b0;
  logic [3:0] gnt_r, state_r;
  logic [1:0] owner_r;
  logic       terr_r, busy_r;

  bus_grant_fsm #(.NREQ(4), .RR_MODE(0), .TW(8), .TIMEOUT(5), .FREE_CYCLES(1)) u_fp (
    .clk(clk), .rst_n(rst_n), .req(req_f), .done(done_f), .bus_ack(ack_f),
    .gnt(gnt_f), .state(state_f), .owner_id(owner_f), .timeout_err(terr_f), .busy(busy_f)
  );

  bus_grant_fsm #(.NREQ(4), .RR_MODE(1), .TW(8), .TIMEOUT(5), .FREE_CYCLES(1)) u_rr (
    .clk(clk), .rst_n(rst_n), .req(req_r), .done(done_r), .bus_ack(ack_r),
    .gnt(gnt_r), .state(state_r), .owner_id(owner_r), .timeout_err(terr_r), .busy(busy_r)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         sel;
    logic [3:0] st;
    logic [3:0] g;
    logic [1:0] o;
    logic       t;
    int         id;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  int   step_id = 0;

  task automatic push_exp(input bit sel, input logic [3:0] es, input logic [3:0] eg,
                          input logic [1:0] eo, input logic et);
    exp_t e;
    e.sel = sel; e.st = es; e.g = eg; e.o = eo; e.t = et; e.id = step_id;
    step_id++;
    sb_q.push_back(e);
  endtask

  // Drive one cycle of inputs at the falling edge and queue the outputs expected
  // after the following rising edge.
  task automatic step(input bit sel, input logic [3:0] r, input logic [3:0] d, input logic a,
                      input logic [3:0] es, input logic [3:0] eg, input logic [1:0] eo,
                      input logic et);
    @(negedge clk);
    if (sel) begin
      req_r = r; done_r = d; ack_r = a;
    end else begin
      req_f = r; done_f = d; ack_f = a;
    end
    push_exp(sel, es, eg, eo, et);
  endtask

  task automatic chk_direct(input string name, input logic [3:0] st, input logic [3:0] g,
                            input logic [1:0] o, input logic t, input logic b);
    checks++;
    if ({st, g, o, t, b} !== {ST_I, 4'b0000, 2'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL %s got state=%b gnt=%b owner=%0d terr=%b busy=%b expected state=0001 gnt=0000 owner=0 terr=0 busy=0",
               name, st, g, o, t, b);
    end
  endtask

  // Monitor: one scoreboard entry is due after every rising edge.
  always @(posedge clk) begin
    #1;
    if (sb_q.size() > 0) begin
      logic [3:0] st, g;
      logic [1:0] o;
      logic       t, b, eb;
      mon_e = sb_q.pop_front();
      if (mon_e.sel) begin
        st = state_r; g = gnt_r; o = owner_r; t = terr_r; b = busy_r;
      end else begin
        st = state_f; g = gnt_f; o = owner_f; t = terr_f; b = busy_f;
      end
      eb = mon_e.st[1] | mon_e.st[2];
      checks++;
      if ({st, g, o, t, b} !== {mon_e.st, mon_e.g, mon_e.o, mon_e.t, eb}) begin
        errors++;
        $display("FAIL step%0d dut=%s got state=%b gnt=%b owner=%0d terr=%b busy=%b expected state=%b gnt=%b owner=%0d terr=%b busy=%b",
                 mon_e.id, mon_e.sel ? "rr" : "fp", st, g, o, t, b,
                 mon_e.st, mon_e.g, mon_e.o, mon_e.t, eb);
      end
    end
  end

  initial begin
    logic [3:0] oh;
    logic [1:0] o;
    #2 rst_n = 1'b0;
    #1;
    chk_direct("reset_fp", state_f, gnt_f, owner_f, terr_f, busy_f);
    chk_direct("reset_rr", state_r, gnt_r, owner_r, terr_r, busy_r);
    @(negedge clk) rst_n = 1'b1;

    // Fixed priority: 1010 -> requester 1, full handshake, then regrant.
    step(0, 4'b1010, 4'b0000, 1'b0, ST_W, 4'b0010, 2'd1, 1'b0);
    step(0, 4'b1010, 4'b0000, 1'b1, ST_B, 4'b0010, 2'd1, 1'b0);
    step(0, 4'b1010, 4'b0010, 1'b0, ST_F, 4'b0000, 2'd1, 1'b0);
    step(0, 4'b1010, 4'b0000, 1'b0, ST_I, 4'b0000, 2'd1, 1'b0);
    step(0, 4'b1010, 4'b0000, 1'b0, ST_W, 4'b0010, 2'd1, 1'b0);
    step(0, 4'b1010, 4'b0000, 1'b1, ST_B, 4'b0010, 2'd1, 1'b0);
    // Non-owner done is ignored; owner dropping req releases.
    step(0, 4'b1010, 4'b1000, 1'b0, ST_B, 4'b0010, 2'd1, 1'b0);
    step(0, 4'b0000, 4'b0000, 1'b0, ST_F, 4'b0000, 2'd1, 1'b0);
    step(0, 4'b0000, 4'b0000, 1'b0, ST_I, 4'b0000, 2'd1, 1'b0);

    // Timeout: entry to BWAIT, four more waiting edges, pulse on the fifth.
    step(0, 4'b0100, 4'b0000, 1'b0, ST_W, 4'b0100, 2'd2, 1'b0);
    step(0, 4'b0100, 4'b0000, 1'b0, ST_W, 4'b0100, 2'd2, 1'b0);
    step(0, 4'b0100, 4'b0000, 1'b0, ST_W, 4'b0100, 2'd2, 1'b0);
    step(0, 4'b0100, 4'b0000, 1'b0, ST_W, 4'b0100, 2'd2, 1'b0);
    step(0, 4'b0100, 4'b0000, 1'b0, ST_W, 4'b0100, 2'd2, 1'b0);
    step(0, 4'b0100, 4'b0000, 1'b0, ST_F, 4'b0000, 2'd2, 1'b1);
    step(0, 4'b0100, 4'b0000, 1'b0, ST_I, 4'b0000, 2'd2, 1'b0);

    // Abort in BWAIT: no timeout pulse.
    step(0, 4'b0100, 4'b0000, 1'b0, ST_W, 4'b0100, 2'd2, 1'b0);
    step(0, 4'b0000, 4'b0000, 1'b0, ST_F, 4'b0000, 2'd2, 1'b0);
    step(0, 4'b0000, 4'b0000, 1'b0, ST_I, 4'b0000, 2'd2, 1'b0);

    // Ack and req drop on the same edge: ack wins.
    step(0, 4'b0001, 4'b0000, 1'b0, ST_W, 4'b0001, 2'd0, 1'b0);
    step(0, 4'b0000, 4'b0000, 1'b1, ST_B, 4'b0001, 2'd0, 1'b0);
    step(0, 4'b0000, 4'b0000, 1'b0, ST_F, 4'b0000, 2'd0, 1'b0);
    step(0, 4'b0000, 4'b0000, 1'b0, ST_I, 4'b0000, 2'd0, 1'b0);

    // Asynchronous reset in the middle of BBUSY.
    step(0, 4'b0001, 4'b0000, 1'b0, ST_W, 4'b0001, 2'd0, 1'b0);
    step(0, 4'b0001, 4'b0000, 1'b1, ST_B, 4'b0001, 2'd0, 1'b0);
    @(negedge clk);
    ack_f = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_direct("async_reset_fp", state_f, gnt_f, owner_f, terr_f, busy_f);
    @(negedge clk) rst_n = 1'b1;
    step(0, 4'b0001, 4'b0000, 1'b0, ST_W, 4'b0001, 2'd0, 1'b0);
    step(0, 4'b0001, 4'b0000, 1'b1, ST_B, 4'b0001, 2'd0, 1'b0);

    // Illegal state 0110 recovers to IDLE with no grant on the next edge.
    @(negedge clk);
    ack_f = 1'b0;
    force u_fp.state_q = 4'b0110;
    #1;
    release u_fp.state_q;
    push_exp(0, ST_I, 4'b0000, 2'd0, 1'b0);
    step(0, 4'b0001, 4'b0000, 1'b0, ST_W, 4'b0001, 2'd0, 1'b0);
    step(0, 4'b0000, 4'b0000, 1'b0, ST_F, 4'b0000, 2'd0, 1'b0);
    step(0, 4'b0000, 4'b0000, 1'b0, ST_I, 4'b0000, 2'd0, 1'b0);

    // Round-robin with all requesters active: owners 0,1,2,3,0.
    for (int k = 0; k < 5; k++) begin
      o  = 2'(k % 4);
      oh = 4'b0001 << o;
      step(1, 4'b1111, 4'b0000, 1'b0, ST_W, oh, o, 1'b0);
      step(1, 4'b1111, 4'b0000, 1'b1, ST_B, oh, o, 1'b0);
      step(1, 4'b1111, oh,      1'b0, ST_F, 4'b0000, o, 1'b0);
      step(1, 4'b1111, 4'b0000, 1'b0, ST_I, 4'b0000, o, 1'b0);
    end
    step(1, 4'b0000, 4'b0000, 1'b0, ST_I, 4'b0000, 2'd0, 1'b0);

    repeat (3) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending entries, expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bus_grant_fsm.md
# bus_grant_fsm

Parametrised bus-ownership controller: arbitrates NREQ requesters onto one shared bus using a one-hot FSM (IDLE, BBUSY, BWAIT, BFREE), with fixed-priority or round-robin selection. It adds an acknowledge timeout, requester abort, a programmable free/turnaround period and illegal-state recovery. It sits between the requesting masters and the shared bus target. All outputs are registered.

## Interface
- NREQ, 4: number of requesters (2..16); OW = max(1, $clog2(NREQ)).
- RR_MODE, 0: 0 = fixed priority (lowest index wins); 1 = round-robin.
- TW, 8: width of the acknowledge-timeout counter.
- TIMEOUT, 200: cycles spent in BWAIT without bus_ack before abort (1..2^TW-1).
- FREE_CYCLES, 1: cycles spent in BFREE (1..15).

- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NREQ  per-requester request level.
- done  in  NREQ  per-requester release pulse; only the owner's bit is honoured.
- bus_ack  in  1  target accepted the granted owner.
- gnt  out  NREQ  one-hot grant; all zero when no owner.
- state  out  4  one-hot state: bit0 IDLE, bit1 BBUSY, bit2 BWAIT, bit3 BFREE.
- owner_id  out  OW  index of the current/last owner.
- timeout_err  out  1  one-cycle pulse on acknowledge timeout.
- busy  out  1  high in BWAIT or BBUSY.

## Operation
- Reset values: state = 4'b0001, gnt = 0, owner_id = 0, timeout_err = 0, busy = 0; round-robin pointer = 0; counters = 0.
- Winner selection:
  - Fixed priority: lowest set index of req.
  - Round-robin: first set index at or after the pointer, wrapping modulo NREQ.
  - On every grant the pointer becomes (winner+1) mod NREQ; NREQ-1 wraps to 0.
- IDLE:
  - req == 0: stay.
  - Otherwise: load winner into owner_id, set gnt[winner], clear the timeout counter, go BWAIT.
- BWAIT:
  - bus_ack = 1: go BBUSY.
  - Otherwise, if req[owner] = 0: abort to BFREE, with no timeout_err.
  - Otherwise, if counter = TIMEOUT-1: pulse timeout_err, go BFREE.
  - Otherwise: increment the counter.
  - Priority when events coincide: bus_ack > abort > timeout.
- BBUSY:
  - done[owner_id] = 1 or req[owner_id] = 0: go BFREE.
  - done bits of non-owners are ignored.
- BFREE:
  - gnt = 0; requests are not sampled.
  - Count FREE_CYCLES cycles, then go IDLE. owner_id holds its last value.
- Illegal state (any value that is not exactly one-hot): next cycle go IDLE with gnt = 0 and no timeout_err.
- Requests that arrive in BBUSY, BWAIT or BFREE wait; there is no preemption.

## Timing
- Request accepted at edge k (state IDLE, req ≠ 0): after edge k, state = BWAIT, gnt and owner_id valid, busy = 1.
- bus_ack high at edge m in BWAIT: BBUSY after edge m.
- done[owner] at edge n in BBUSY: after edge n, state = BFREE, gnt = 0, busy = 0.
- BFREE lasts exactly FREE_CYCLES edges; IDLE follows. Minimum release-to-next-grant gap = FREE_CYCLES + 1 edges.
- Timeout: after entering BWAIT at edge k with no ack, timeout_err = 1 after edge k+TIMEOUT only, and state = BFREE from the same edge.
- rst_n low at any time, including mid-BBUSY: outputs take their reset values immediately (asynchronous). Deassertion is synchronous to clk; the first grant is possible at the first edge after release.

## Test plan
- Fixed priority, RR_MODE=0: req = 4'b1010 held in IDLE -> gnt = 4'b0010, owner_id = 1, state = 4'b0100; then bus_ack -> state = 4'b0010; done[1] -> BFREE for 1 cycle, then IDLE, then regrant of 1.
- Round-robin, RR_MODE=1, all req = 4'b1111 held; each grant completed with ack+done -> owners 0,1,2,3,0 in order; the pointer wraps from 3 to 0.
- Timeout, TIMEOUT=5: grant with bus_ack held 0 -> exactly one timeout_err pulse 5 edges after entering BWAIT, then BFREE, then IDLE; gnt = 0 throughout BFREE.
- Abort and coincidence:
  - Owner drops req in BWAIT -> BFREE, no timeout_err.
  - bus_ack and req drop on the same edge -> BBUSY.
  - done on a non-owner bit in BBUSY -> no transition.
- Reset mid-BBUSY: rst_n low -> gnt = 0, state = 4'b0001, busy = 0 with no clock edge; force state to 4'b0110 -> IDLE on the next edge.
